// File: rtl/dmem_bus_adapter_if.sv
// Data-memory bus bundle between the MEM-stage adapter and a variable-latency
// memory. Handshake: the master raises bus_req together with stable bus_we,
// bus_addr and bus_wdata, and holds all four unchanged until the slave returns
// a single-cycle bus_ack (with bus_rdata valid in that same cycle for reads);
// the master then drops bus_req on the following edge.
interface dmem_bus_adapter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/dmem_bus_adapter.sv
// Converts the single-cycle MEM-stage load/store request into a req/ack bus
// transaction, stalls the pipeline while the access is outstanding and reports
// misaligned, illegal (load and store together) and timed-out accesses.
module dmem_bus_adapter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_stall,
  output logic                  err_pulse,
  output logic [1:0]            err_code,
  output logic [1:0]            dbg_state,
  dmem_bus_adapter_if.master    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_MISALGN = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Counter index of the last REQ cycle allowed before the access is aborted.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state;
  logic [15:0]           cnt;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  access;

  assign access    = mem_ren | mem_wen;
  // The pipeline is released only in DONE, where WB captures mem_din.
  assign mem_stall = access & (state != ST_DONE);
  assign mem_din   = rdata;
  assign dbg_state = state;

  // Request FSM: samples the MEM-stage request in IDLE, runs the bus handshake
  // in REQ and presents the result for exactly one cycle in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      rdata         <= '0;
      err_pulse     <= 1'b0;
      err_code      <= ERR_NONE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (mem_ren && mem_wen) begin
              rdata     <= '0;
              err_code  <= ERR_ILLEGAL;
              err_pulse <= 1'b1;
              state     <= ST_DONE;
            end else if (mem_addr[1:0] != 2'b00) begin
              rdata     <= '0;
              err_code  <= ERR_MISALGN;
              err_pulse <= 1'b1;
              state     <= ST_DONE;
            end else begin
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= mem_wen;
              bus.bus_addr  <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
              bus.bus_wdata <= mem_dout;
              cnt           <= '0;
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            rdata       <= bus.bus_we ? '0 : bus.bus_rdata;
            err_code    <= ERR_NONE;
            state       <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            bus.bus_req <= 1'b0;
            rdata       <= '0;
            err_code    <= ERR_TIMEOUT;
            err_pulse   <= 1'b1;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_bus_adapter.md
Name: dmem_bus_adapter

Overview:
- Downstream neighbour of the pipelined datapath's MEM stage. It consumes the MEM-stage memory request: mem_ren, mem_wen, mem_addr and mem_dout.
- It converts that single-cycle request into a req/ack handshake toward a variable-latency data-memory bus, and returns read data on mem_din.
- While an access is outstanding it asserts mem_stall. The pipeline controller uses mem_stall to hold IF..MEM enables and to bubble WB.
- It detects misaligned, illegal and timed-out accesses and reports them.

Parameters:
- ADDR_WIDTH, 32, width of mem_addr and bus_addr.
- DATA_WIDTH, 32, width of all data buses.
- TIMEOUT_CYCLES, 255, maximum cycles in REQ without bus_ack before abort. Legal range 1..65535.

Ports:
- clk  input  1  main clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_ren  input  1  read request from MEM stage, level.
- mem_wen  input  1  write request from MEM stage, level.
- mem_addr  input  ADDR_WIDTH  byte address (ALU result of MEM stage).
- mem_dout  input  DATA_WIDTH  store data from MEM stage.
- mem_din  output  DATA_WIDTH  load data to datapath; valid in DONE.
- mem_stall  output  1  hold pipeline; combinational.
- bus_req  output  1  bus request, registered.
- bus_we  output  1  1 = write, 0 = read, registered.
- bus_addr  output  ADDR_WIDTH  word-aligned bus address, registered.
- bus_wdata  output  DATA_WIDTH  write data, registered.
- bus_ack  input  1  one-cycle completion strobe from memory.
- bus_rdata  input  DATA_WIDTH  read data; sampled only with bus_ack.
- err_pulse  output  1  one-cycle error flag, asserted in DONE.
- err_code  output  2  0 none, 1 misaligned, 2 illegal (ren & wen), 3 timeout; held until next DONE.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = IDLE; bus_req = bus_we = 0; bus_addr = bus_wdata = 0.
  - rdata register = 0, so mem_din = 0.
  - err_pulse = 0, err_code = 0, timeout counter = 0.
  - Reset mid-access drops bus_req immediately. A late bus_ack after reset is ignored.
- Define access = mem_ren | mem_wen.
- mem_stall = access & (state != DONE). It is therefore 1 in IDLE-with-access and in REQ, and 0 in DONE.
- State IDLE:
  - No access: stay in IDLE.
  - Access with mem_ren & mem_wen: go to DONE with err_code = 2. No bus transaction.
  - Access with mem_addr[1:0] != 0: go to DONE with err_code = 1. No bus transaction.
  - Otherwise: latch bus_we = mem_wen, bus_addr = mem_addr, bus_wdata = mem_dout; set bus_req = 1; clear counter; go to REQ.
- State REQ:
  - bus_req, bus_we, bus_addr and bus_wdata are held stable.
  - On bus_ack: bus_req = 0; for a read, capture bus_rdata into rdata; for a write, rdata = 0; err_code = 0; go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without ack: bus_req = 0, rdata = 0, err_code = 3, go to DONE.
  - bus_ack and timeout in the same cycle: ack wins.
- State DONE:
  - Lasts exactly 1 cycle. mem_din = rdata; err_pulse = (err_code != 0).
  - The pipeline advances at the end of this cycle (WB captures mem_din). Next state is IDLE.
- mem_din equals rdata in all states. Its value is meaningful only in DONE.
- Latency, with the request visible in cycle N:
  - bus_req rises in N+1.
  - With ack in N+k (k >= 1), DONE occurs in N+k+1.
  - Minimum stall is 2 cycles (N and N+1); a zero-wait bus yields DONE in N+2.
- Back-to-back accesses: the next MEM-stage instruction is visible in the cycle after DONE and is handled from IDLE. There is no lost or duplicated request.
- bus_ack while in IDLE or DONE is ignored and does not alter state or rdata.
- The request inputs are sampled only in IDLE. Changes in REQ or DONE have no effect.
- Error paths: for misaligned or illegal accesses, mem_stall is high for exactly 1 cycle (IDLE), then DONE.

Test Plan:
- Load, zero-wait: mem_ren = 1, addr 0x0000_0010, bus_ack one cycle after bus_req with rdata 0x1234_5678 -> bus_req high 1 cycle, bus_we = 0, bus_addr = 0x10, mem_stall high 2 cycles, mem_din = 0x1234_5678 in DONE, err_pulse = 0.
- Store, 3-wait: mem_wen = 1, addr 0x20, dout 0xCAFE_F00D, ack on the 4th bus_req cycle -> bus_wdata = 0xCAFE_F00D stable throughout, mem_stall high 5 cycles, mem_din = 0.
- Misaligned: mem_ren = 1, addr 0x0000_0013 -> bus_req never asserted, 1 stall cycle, DONE with err_pulse = 1, err_code = 1, mem_din = 0.
- Illegal/timeout:
  - mem_ren = mem_wen = 1 -> err_code = 2, no bus_req.
  - With TIMEOUT_CYCLES = 4 and no ack -> bus_req high 4 cycles, then err_code = 3 and err_pulse = 1.
- Reset mid-access: assert rst_n = 0 while in REQ, between clock edges -> bus_req falls without a clock edge; after release, a stray bus_ack is ignored; a new load completes normally.
- Back-to-back: a load to 0x40 immediately followed by a store to 0x44, with a 1-wait bus -> two distinct transactions in order, no gap beyond one IDLE cycle, correct mem_din for the load.
